// File: rtl/index_mask_decoder.sv
// index_mask_decoder
//   Keeps a registered occupancy mask of M = 2**N slots. A set request
//   turns a binary index into a one-hot bit and ORs it into the mask. A clear
//   request removes a bit the same way. Flush empties the whole mask.
//   The block also registers a one-hot copy of the last accepted set index,
//   the population count, and full/empty flags. All of these come from the
//   same next-mask value, so they always agree with each other.
//   Optional feature: define INDEX_MASK_DECODER_ERR_CHECK_EN to get a sticky
//   error flag for redundant sets and clears. When the macro is undefined,
//   err is tied to 0.

module index_mask_decoder #(
  parameter int N = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               set_valid,
  input  logic [N-1:0]       set_index,
  input  logic               clr_valid,
  input  logic [N-1:0]       clr_index,
  input  logic               flush,
  output logic [(1<<N)-1:0]  mask,
  output logic               dec_valid,
  output logic [(1<<N)-1:0]  dec_onehot,
  output logic [N:0]         count,
  output logic               full,
  output logic               empty,
  output logic               err
);

  localparam int         M      = 1 << N;
  localparam logic [N:0] C_FULL = (N+1)'(M);
  localparam logic [N:0] C_ZERO = {(N+1){1'b0}};

  // One-hot decode of a binary index. Every index is in range.
  function automatic logic [M-1:0] f_dec(input logic [N-1:0] idx);
    return {{(M-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Count the ones in a mask vector.
  function automatic logic [N:0] f_popcount(input logic [M-1:0] v);
    logic [N:0] c;
    c = C_ZERO;
    for (int k = 0; k < M; k++) begin
      c = c + {{N{1'b0}}, v[k]};
    end
    return c;
  endfunction

  logic [M-1:0] r_mask;
  logic         r_dec_valid;
  logic [M-1:0] r_dec_onehot;
  logic [N:0]   r_count;
  logic         r_full;
  logic         r_empty;

  logic [M-1:0] w_set_dec;
  logic [M-1:0] w_clr_dec;
  logic [M-1:0] w_mask_next;
  logic         w_dec_valid_next;
  logic [N:0]   w_count_next;
  logic         w_full_next;
  logic         w_empty_next;

  // Gate the one-hot decodes with their valids.
  always_comb begin
    w_set_dec = {M{1'b0}};
    w_clr_dec = {M{1'b0}};
    if (set_valid) begin
      w_set_dec = f_dec(set_index);
    end else begin
      w_set_dec = {M{1'b0}};
    end
    if (clr_valid) begin
      w_clr_dec = f_dec(clr_index);
    end else begin
      w_clr_dec = {M{1'b0}};
    end
  end

  // Next mask: flush has priority. Otherwise clear first and then set,
  // so a set and a clear of the same index leave the bit at 1.
  always_comb begin
    w_mask_next = r_mask;
    if (flush) begin
      w_mask_next = {M{1'b0}};
    end else begin
      w_mask_next = (r_mask & ~w_clr_dec) | w_set_dec;
    end
  end

  // Count and flags come from the next mask. Count can never wrap.
  always_comb begin
    w_dec_valid_next = set_valid & ~flush;
    w_count_next     = f_popcount(w_mask_next);
    w_full_next      = (w_count_next == C_FULL);
    w_empty_next     = (w_count_next == C_ZERO);
  end

  // State register for the mask, decode and derived flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask       <= {M{1'b0}};
      r_dec_valid  <= 1'b0;
      r_dec_onehot <= {M{1'b0}};
      r_count      <= C_ZERO;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
    end else begin
      r_mask      <= w_mask_next;
      r_dec_valid <= w_dec_valid_next;
      if (w_dec_valid_next) begin
        r_dec_onehot <= f_dec(set_index);
      end
      r_count <= w_count_next;
      r_full  <= w_full_next;
      r_empty <= w_empty_next;
    end
  end

`ifdef INDEX_MASK_DECODER_ERR_CHECK_EN
  logic r_err;
  logic w_err_event;
  logic w_same_idx;

  // Flag a redundant set or a redundant clear. A redundant set does not
  // count when the same cycle also clears that index, because the clear
  // and set together re-assert the bit on purpose.
  always_comb begin
    w_same_idx  = clr_valid & (clr_index == set_index);
    w_err_event = 1'b0;
    if (flush) begin
      w_err_event = 1'b0;
    end else begin
      w_err_event = (set_valid & (|(w_set_dec & r_mask)) & ~w_same_idx) |
                    (clr_valid & ~(|(w_clr_dec & r_mask)));
    end
  end

  // Sticky error flag. Only reset clears it; flush does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | w_err_event;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign mask       = r_mask;
  assign dec_valid  = r_dec_valid;
  assign dec_onehot = r_dec_onehot;
  assign count      = r_count;
  assign full       = r_full;
  assign empty      = r_empty;

endmodule

// File: tb/tb_index_mask_decoder.sv
// Scoreboard bench for index_mask_decoder (N=3).
// The stimulus drives on falling edges and pushes the expected state.
// A monitor pops one entry per rising edge (sampled #1 later) and compares.
module tb_index_mask_decoder;

`ifdef INDEX_MASK_DECODER_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       set_valid;
  logic [2:0] set_index;
  logic       clr_valid;
  logic [2:0] clr_index;
  logic       flush;
  logic [7:0] mask;
  logic       dec_valid;
  logic [7:0] dec_onehot;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       err;

  index_mask_decoder #(.N(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .set_valid(set_valid), .set_index(set_index),
    .clr_valid(clr_valid), .clr_index(clr_index),
    .flush(flush),
    .mask(mask), .dec_valid(dec_valid), .dec_onehot(dec_onehot),
    .count(count), .full(full), .empty(empty), .err(err)
  );

  typedef struct {
    logic [7:0] m;
    logic       dv;
    logic [7:0] oh;
    logic [3:0] c;
    logic       f;
    logic       e;
    logic       er;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   e_err = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor process: compare the DUT state against the oldest expected entry.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("mask", {8'h00, mask}, {8'h00, x.m});
        chk("dec_valid", {15'h0, dec_valid}, {15'h0, x.dv});
        chk("dec_onehot", {8'h00, dec_onehot}, {8'h00, x.oh});
        chk("count", {12'h000, count}, {12'h000, x.c});
        chk("full", {15'h0, full}, {15'h0, x.f});
        chk("empty", {15'h0, empty}, {15'h0, x.e});
        chk("err", {15'h0, err}, {15'h0, x.er});
      end
    end
  end

  task automatic step(input bit sv, input logic [2:0] si, input bit cv, input logic [2:0] ci,
                      input bit fl, input logic [7:0] em, input bit edv, input logic [7:0] eoh,
                      input logic [3:0] ec, input bit ef, input bit ee);
    exp_t x;
    @(negedge clk);
    set_valid = sv; set_index = si; clr_valid = cv; clr_index = ci; flush = fl;
    x.m = em; x.dv = edv; x.oh = eoh; x.c = ec; x.f = ef; x.e = ee; x.er = e_err;
    q.push_back(x);
  endtask

  task automatic idle_drain();
    int n;
    @(negedge clk);
    set_valid = 1'b0; clr_valid = 1'b0; flush = 1'b0; set_index = 3'd0; clr_index = 3'd0;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain actual=%0d required=0 pending entries", q.size());
      q.delete();
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_mask"}, {8'h00, mask}, 16'h0000);
    chk({tag, "_dv"}, {15'h0, dec_valid}, 16'h0000);
    chk({tag, "_oh"}, {8'h00, dec_onehot}, 16'h0000);
    chk({tag, "_count"}, {12'h000, count}, 16'h0000);
    chk({tag, "_full"}, {15'h0, full}, 16'h0000);
    chk({tag, "_empty"}, {15'h0, empty}, 16'h0001);
    chk({tag, "_err"}, {15'h0, err}, 16'h0000);
  endtask

  task automatic do_reset();
    idle_drain();
    rst_n = 1'b0;
    #1;
    check_reset_state("rst");
    e_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int ev;
    rst_n = 1'b0; set_valid = 1'b0; clr_valid = 1'b0; flush = 1'b0;
    set_index = 3'd0; clr_index = 3'd0;
    #12;
    check_reset_state("init");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill slots 0..7, one per cycle.
    for (int i = 0; i < 8; i++) begin
      ev = (1 << (i + 1)) - 1;
      step(1'b1, 3'(i), 1'b0, 3'd0, 1'b0, 8'(ev), 1'b1, 8'(1 << i), 4'(i + 1), (i == 7), 1'b0);
    end
    // Set while full: mask stays the same, decode still updates.
    e_err = ERR_EN;
    step(1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 8'hFF, 1'b1, 8'h04, 4'd8, 1'b1, 1'b0);
    // Set 4 plus clear 6 while full gives M-1.
    step(1'b1, 3'd4, 1'b1, 3'd6, 1'b0, 8'hBF, 1'b1, 8'h10, 4'd7, 1'b0, 1'b0);
    step(1'b1, 3'd6, 1'b0, 3'd0, 1'b0, 8'hFF, 1'b1, 8'h40, 4'd8, 1'b1, 1'b0);
    // Clear 5, then clear 7.
    step(1'b0, 3'd0, 1'b1, 3'd5, 1'b0, 8'hDF, 1'b0, 8'h40, 4'd7, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b1, 3'd7, 1'b0, 8'h5F, 1'b0, 8'h40, 4'd6, 1'b0, 1'b0);
    // Flush to empty, then clear while empty.
    step(1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 8'h40, 4'd0, 1'b0, 1'b1);
    step(1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 8'h00, 1'b0, 8'h40, 4'd0, 1'b0, 1'b1);
    // Set and clear of the same index: the set wins.
    step(1'b1, 3'd3, 1'b1, 3'd3, 1'b0, 8'h08, 1'b1, 8'h08, 4'd1, 1'b0, 1'b0);
    step(1'b1, 3'd1, 1'b1, 3'd3, 1'b0, 8'h02, 1'b1, 8'h02, 4'd1, 1'b0, 1'b0);
    // Build 8'h2F, then flush together with a set of index 6.
    step(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 8'h03, 1'b1, 8'h01, 4'd2, 1'b0, 1'b0);
    step(1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 8'h07, 1'b1, 8'h04, 4'd3, 1'b0, 1'b0);
    step(1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 8'h0F, 1'b1, 8'h08, 4'd4, 1'b0, 1'b0);
    step(1'b1, 3'd5, 1'b0, 3'd0, 1'b0, 8'h2F, 1'b1, 8'h20, 4'd5, 1'b0, 1'b0);
    step(1'b1, 3'd6, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 8'h20, 4'd0, 1'b0, 1'b1);

    // Error flag: a redundant set raises it, and a flush leaves it set.
    do_reset();
    step(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 8'h01, 1'b1, 8'h01, 4'd1, 1'b0, 1'b0);
    e_err = ERR_EN;
    step(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 8'h01, 1'b1, 8'h01, 4'd1, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 8'h01, 4'd0, 1'b0, 1'b1);
    do_reset();

    // Build 8'hA5, then apply an asynchronous reset between clock edges.
    step(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 8'h01, 1'b1, 8'h01, 4'd1, 1'b0, 1'b0);
    step(1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 8'h05, 1'b1, 8'h04, 4'd2, 1'b0, 1'b0);
    step(1'b1, 3'd5, 1'b0, 3'd0, 1'b0, 8'h25, 1'b1, 8'h20, 4'd3, 1'b0, 1'b0);
    step(1'b1, 3'd7, 1'b0, 3'd0, 1'b0, 8'hA5, 1'b1, 8'h80, 4'd4, 1'b0, 1'b0);
    idle_drain();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_state("async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/index_mask_decoder.md
Name: index_mask_decoder

Overview:
- Decoder-side counterpart of the priority encoder. It converts binary slot indices back to one-hot form and keeps a registered occupancy mask of 2**N slots.
- Intended for cache-way and replacement bookkeeping. The encoder picks a slot from a mask; this block sets or clears the mask bit for a given index.
- Provides a registered one-hot decode of the last accepted set index, the population count, and full/empty flags.

Parameters:
- N, 3, index width; the mask width is M = 2**N.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- set_valid  input  1  request to set the mask bit at set_index
- set_index  input  N  binary index to set
- clr_valid  input  1  request to clear the mask bit at clr_index
- clr_index  input  N  binary index to clear
- flush  input  1  clears the whole mask
- mask  output  M  registered occupancy mask
- dec_valid  output  1  registered; high for one cycle after an accepted set
- dec_onehot  output  M  registered one-hot of the last accepted set_index
- count  output  N+1  registered number of ones in mask (0..M)
- full  output  1  registered; mask all ones (count == M)
- empty  output  1  registered; mask all zeros (count == 0)
- err  output  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-low):
  - mask = 0, dec_onehot = 0, dec_valid = 0, count = 0, full = 0, empty = 1, err = 0.
  - Reset asserted mid-operation discards any in-flight request immediately.
- All state updates on the rising clk edge. Latency from request to mask/count/flags/dec_* is 1 cycle. Outputs never depend combinationally on inputs.
- Decode function: dec(i) = 1 << i, M bits wide. Every index 0..M-1 is legal, so no out-of-range case exists.
- Next-state priority, highest first:
  1. flush: mask_next = 0, dec_valid_next = 0, dec_onehot holds. set/clr in the same cycle are ignored.
  2. Otherwise: mask_next = (mask & ~(clr_valid ? dec(clr_index) : 0)) | (set_valid ? dec(set_index) : 0).
- Simultaneous set and clr on the same index: the set wins and the bit ends at 1.
- Simultaneous set and clr on different indices: both are applied in the same cycle.
- Set on an already-set bit: mask unchanged, but dec_valid/dec_onehot still update.
- Clear on an already-clear bit: no change.
- dec_valid_next = set_valid & ~flush. dec_onehot loads dec(set_index) only when dec_valid_next = 1; otherwise it holds.
- count_next = popcount(mask_next); full and empty are derived from count_next and registered with mask, so all four stay mutually consistent every cycle.
- Full boundary: a set when full with no clr leaves the mask unchanged. A set plus a clr on different indices when full gives count = M-1.
- Empty boundary: a clr when empty leaves the mask unchanged; count cannot underflow.
- No wrap-around: count saturates structurally because it is computed from the mask, never from increment/decrement arithmetic.

Optional Feature:
- Macro: INDEX_MASK_DECODER_ERR_CHECK_EN.
- Defined: err is set to 1 on the clock edge after either illegal event, and stays 1 until reset:
  - an accepted set to a bit that is already 1 in mask, unless the same cycle also clears that same index;
  - a clr to a bit that is already 0, with no flush that cycle.
- Defined: flush does not clear err; only rst_n clears it.
- Not defined: err is tied to 0 and no checking logic is synthesized. All other behaviour is identical.

Test Plan (N=3):
- Reset, then set indices 0..7 one per cycle -> after each cycle dec_onehot = 1<<i and dec_valid = 1. Final mask = 8'hFF, count = 8, full = 1, empty = 0.
- From mask 8'hFF: clr 5, then clr 7 -> mask 8'hDF then 8'h5F, count 7 then 6, full = 0.
- Same cycle, from mask 8'h00: set_index = 3 with clr_index = 3 -> mask 8'h08. Next cycle, set 1 with clr 3 -> mask 8'h02, count = 1.
- flush with set_valid on index 6, from mask 8'h2F -> mask 8'h00, empty = 1, dec_valid = 0, dec_onehot unchanged.
- With INDEX_MASK_DECODER_ERR_CHECK_EN defined: from mask 8'h01, set 0 -> err = 1 next cycle. err stays 1 through a flush and clears only on rst_n low. Same stimulus without the macro -> err stays 0.
- Assert rst_n low asynchronously between edges with mask 8'hA5 -> mask = 0, count = 0 and empty = 1 immediately, without waiting for a clock edge.
